rot_stream_16b: RTL

ROT_STREAM_16B -- requirements
Module: rot_stream_16b

---
 rtl/rot_stream_16b_pkg.sv | 22 ++
 rtl/rot_r_core_16b.sv | 22 ++
 rtl/rot_stream_16b.sv | 83 ++++++++
 3 files changed

// File: rtl/rot_stream_16b_pkg.sv
// Shared definitions for the 16-bit rotate stream: data/amount widths,
// direction encoding and the left-to-right amount conversion.
package rot_stream_16b_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic {
    ROT_R = 1'b0,
    ROT_L = 1'b1
  } rot_dir_e;

  // A left rotate by n equals a right rotate by (DATA_W - n) mod DATA_W,
  // which is simply the two's-complement negation of the amount.
  function automatic logic [AMT_W-1:0] eff_right_amt(input rot_dir_e dir,
                                                     input logic [AMT_W-1:0] amt);
    logic [AMT_W-1:0] neg;
    neg = ~amt + {{(AMT_W-1){1'b0}}, 1'b1};
    return (dir == ROT_L) ? neg : amt;
  endfunction

endpackage

// File: rtl/rot_r_core_16b.sv
// Combinational 16-bit right rotator built as a log-shifter: four cascaded
// conditional rotations by 1, 2, 4 and 8 bits.
module rot_r_core_16b
  import rot_stream_16b_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] s4;

  always_comb begin
    s1     = amt[0] ? {data[0],   data[DATA_W-1:1]} : data;
    s2     = amt[1] ? {s1[1:0],   s1[DATA_W-1:2]}   : s1;
    s4     = amt[2] ? {s2[3:0],   s2[DATA_W-1:4]}   : s2;
    result = amt[3] ? {s4[7:0],   s4[DATA_W-1:8]}   : s4;
  end

endmodule

// File: rtl/rot_stream_16b.sv
// Two-stage valid/ready rotate pipeline: stage 1 captures operand and
// effective right amount, stage 2 holds the rotated result.
module rot_stream_16b
  import rot_stream_16b_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  logic              vld_p1;
  logic              vld_p2;
  logic [DATA_W-1:0] data_p1;
  logic [AMT_W-1:0]  amt_p1;
  logic [DATA_W-1:0] data_p2;
  logic [DATA_W-1:0] rot_p1;
  logic              rdy_p1;
  logic              rdy_p2;

  // A stage may load when empty or when its contents move on this edge.
  assign rdy_p2   = !vld_p2 || out_ready;
  assign rdy_p1   = !vld_p1 || rdy_p2;
  assign in_ready = rdy_p1;

  // ---- stage 1: operand and effective right amount
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (rdy_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy_p1 && in_valid) begin
      data_p1 <= in_data;
      amt_p1  <= eff_right_amt(rot_dir_e'(in_dir), in_amt);
    end
  end

  rot_r_core_16b u_core (
    .data   (data_p1),
    .amt    (amt_p1),
    .result (rot_p1)
  );

  // ---- stage 2: rotated result, drives out_data directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (rdy_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= rot_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign busy      = vld_p1 || vld_p2;

endmodule
